// File: rtl/bus_arbiter_2m3s.sv
// Two-master, three-slave single-beat bus controller: round-robin arbitration,
// address decode to a one-hot slave select, ready/timeout handling and per-master response.
module bus_arbiter_2m3s #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m0_mode,
    input  logic [15:0] m0_addr,
    input  logic [7:0]  m0_wdata,
    output logic        m0_grant,
    output logic        m0_done,
    output logic        m0_err,
    output logic [7:0]  m0_rdata,
    input  logic        m1_req,
    input  logic        m1_mode,
    input  logic [15:0] m1_addr,
    input  logic [7:0]  m1_wdata,
    output logic        m1_grant,
    output logic        m1_done,
    output logic        m1_err,
    output logic [7:0]  m1_rdata,
    output logic        s_mode,
    output logic [15:0] s_addr,
    output logic [7:0]  s_wdata,
    output logic        s_valid,
    output logic [2:0]  s_sel,
    input  logic [7:0]  s1_rdata,
    input  logic [7:0]  s2_rdata,
    input  logic [7:0]  s3_rdata,
    input  logic        s1_ready,
    input  logic        s2_ready,
    input  logic        s3_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [7:0] TMO = 8'(TIMEOUT);

    state_t      state_q, state_d;
    logic        ptr_q, ptr_d;
    logic        owner_q, owner_d;
    logic        mode_q, mode_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [2:0]  sel_q, sel_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    logic [7:0]  rdata0_q, rdata0_d;
    logic [7:0]  rdata1_q, rdata1_d;

    logic        win;
    logic [2:0]  hit_sel;
    logic [7:0]  cap;
    logic        sel_ready;
    logic [7:0]  sel_rdata;
    logic        busy;

    function automatic logic [2:0] decode(input logic [3:0] page);
        case (page)
            4'h0:    decode = 3'b001;
            4'h1:    decode = 3'b010;
            4'h2:    decode = 3'b100;
            default: decode = 3'b000;
        endcase
    endfunction

    // Only the selected slave's handshake is observed; the others are masked off.
    assign sel_ready = |(sel_q & {s3_ready, s2_ready, s1_ready});

    always_comb begin
        sel_rdata = 8'h00;
        if (sel_q[0]) begin
            sel_rdata = s1_rdata;
        end else if (sel_q[1]) begin
            sel_rdata = s2_rdata;
        end else if (sel_q[2]) begin
            sel_rdata = s3_rdata;
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        owner_d  = owner_q;
        mode_d   = mode_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        sel_d    = sel_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        win      = 1'b0;
        hit_sel  = 3'b000;
        cap      = 8'h00;
        case (state_q)
            IDLE: begin
                if (m0_req || m1_req) begin
                    win     = (m0_req && m1_req) ? ptr_q : m1_req;
                    owner_d = win;
                    mode_d  = win ? m1_mode  : m0_mode;
                    addr_d  = win ? m1_addr  : m0_addr;
                    wdata_d = win ? m1_wdata : m0_wdata;
                    hit_sel = decode(addr_d[15:12]);
                    sel_d   = hit_sel;
                    if (hit_sel != 3'b000) begin
                        err_d   = 1'b0;
                        state_d = ADDR;
                    end else begin
                        err_d   = 1'b1;
                        state_d = DONE;
                        if (win) begin
                            rdata1_d = 8'h00;
                        end else begin
                            rdata0_d = 8'h00;
                        end
                    end
                end
            end
            ADDR: begin
                cnt_d   = 8'd0;
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q + 8'd1;
                // A ready in the timeout cycle still completes the transfer cleanly.
                if (sel_ready || cnt_d == TMO) begin
                    err_d   = ~sel_ready;
                    cap     = (sel_ready && !mode_q) ? sel_rdata : 8'h00;
                    state_d = DONE;
                    if (owner_q) begin
                        rdata1_d = cap;
                    end else begin
                        rdata0_d = cap;
                    end
                end
            end
            DONE: begin
                ptr_d   = ~ptr_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            ptr_q    <= 1'b0;
            owner_q  <= 1'b0;
            mode_q   <= 1'b0;
            addr_q   <= 16'h0000;
            wdata_q  <= 8'h00;
            sel_q    <= 3'b000;
            cnt_q    <= 8'd0;
            err_q    <= 1'b0;
            rdata0_q <= 8'h00;
            rdata1_q <= 8'h00;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            owner_q  <= owner_d;
            mode_q   <= mode_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            sel_q    <= sel_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    assign busy     = (state_q == ADDR) || (state_q == WAIT);
    assign s_valid  = (state_q == ADDR);
    assign s_sel    = busy ? sel_q : 3'b000;
    assign s_mode   = mode_q;
    assign s_addr   = addr_q;
    assign s_wdata  = wdata_q;

    assign m0_grant = busy & ~owner_q;
    assign m1_grant = busy & owner_q;
    assign m0_done  = (state_q == DONE) & ~owner_q;
    assign m1_done  = (state_q == DONE) & owner_q;
    assign m0_err   = m0_done & err_q;
    assign m1_err   = m1_done & err_q;
    assign m0_rdata = rdata0_q;
    assign m1_rdata = rdata1_q;

endmodule

// File: tb/tb_bus_arbiter_2m3s.sv
// Scoreboard bench for bus_arbiter_2m3s: slave models with fixed latencies, a transaction-level
// reference model that predicts winner order, completion cycle, error and read data.
module tb_bus_arbiter_2m3s;

    localparam int TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_mode, m0_grant, m0_done, m0_err;
    logic [15:0] m0_addr;
    logic [7:0]  m0_wdata, m0_rdata;
    logic        m1_req, m1_mode, m1_grant, m1_done, m1_err;
    logic [15:0] m1_addr;
    logic [7:0]  m1_wdata, m1_rdata;
    logic        s_mode, s_valid;
    logic [15:0] s_addr;
    logic [7:0]  s_wdata;
    logic [2:0]  s_sel;
    logic [7:0]  s1_rdata, s2_rdata, s3_rdata;
    logic        s1_ready, s2_ready, s3_ready;

    bus_arbiter_2m3s #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_mode(m0_mode), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_grant(m0_grant), .m0_done(m0_done), .m0_err(m0_err), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_mode(m1_mode), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_grant(m1_grant), .m1_done(m1_done), .m1_err(m1_err), .m1_rdata(m1_rdata),
        .s_mode(s_mode), .s_addr(s_addr), .s_wdata(s_wdata), .s_valid(s_valid), .s_sel(s_sel),
        .s1_rdata(s1_rdata), .s2_rdata(s2_rdata), .s3_rdata(s3_rdata),
        .s1_ready(s1_ready), .s2_ready(s2_ready), .s3_ready(s3_ready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          m;
        bit          err;
        logic [7:0]  rdata;
        int          dcyc;
        bit          mapped;
        int          vcyc;
        logic [2:0]  sel;
        logic        mode;
        logic [15:0] addr;
        logic [7:0]  wdata;
    } exp_t;

    exp_t       exp_q[$];
    int         n_chk = 0;
    int         n_err = 0;
    bit         ptr_m = 1'b0;
    bit         s2_dead = 1'b0;
    int         stray_cyc = -1;
    bit         mon_en = 1'b0;
    logic [7:0] ref_mem [int];
    logic [7:0] sl_mem [int];
    logic [7:0] last_rd [2] = '{8'h00, 8'h00};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [7:0] def_val(input int k, input logic [11:0] a);
        return a[7:0] ^ (8'h30 + 8'(k));
    endfunction

    function automatic int slave_lat(input int k);
        if (k == 0) return 1;
        if (k == 1) return s2_dead ? 1000 : 2;
        return 4;
    endfunction

    // Reference: one transaction whose request is sampled in IDLE at cycle t.
    task automatic model_txn(input bit m, input logic mode, input logic [15:0] addr,
                             input logic [7:0] wdata, input int t, output int d);
        exp_t e;
        int k, lat, key;
        e.m = m; e.mode = mode; e.addr = addr; e.wdata = wdata;
        e.rdata = 8'h00; e.err = 1'b0;
        k = int'(addr[15:12]);
        if (k > 2) begin
            e.mapped = 1'b0; e.err = 1'b1; e.dcyc = t + 1; e.vcyc = -1; e.sel = 3'b000;
        end else begin
            e.mapped = 1'b1; e.vcyc = t + 1; e.sel = 3'(1 << k);
            lat = slave_lat(k);
            key = k * 4096 + int'(addr[11:0]);
            if (lat > TIMEOUT) begin
                e.err = 1'b1; e.dcyc = t + 2 + TIMEOUT;
            end else begin
                e.dcyc = t + 2 + lat;
                if (mode) ref_mem[key] = wdata;
                else e.rdata = ref_mem.exists(key) ? ref_mem[key] : def_val(k, addr[11:0]);
            end
        end
        exp_q.push_back(e);
        ptr_m = ~ptr_m;
        d = e.dcyc;
    endtask

    // Slaves: ready pulses lat cycles after the s_valid cycle; slave 2 may be dead.
    initial begin
        int         cd[3];
        logic [7:0] rd[3];
        logic [2:0] rdy;
        int         key;
        cd = '{-1, -1, -1};
        rd = '{8'h00, 8'h00, 8'h00};
        s1_ready = 1'b0; s2_ready = 1'b0; s3_ready = 1'b0;
        s1_rdata = 8'hEE; s2_rdata = 8'hEE; s3_rdata = 8'hEE;
        forever begin
            @(negedge clk);
            rdy = 3'b000;
            for (int k = 0; k < 3; k++) begin
                if (cd[k] > 0) begin
                    cd[k]--;
                    if (cd[k] == 0) begin
                        rdy[k] = 1'b1;
                        cd[k] = -1;
                    end
                end
            end
            if (s_valid) begin
                for (int k = 0; k < 3; k++) begin
                    if (s_sel[k] && !(k == 1 && s2_dead)) begin
                        key = k * 4096 + int'(s_addr[11:0]);
                        if (s_mode) sl_mem[key] = s_wdata;
                        rd[k] = s_mode ? 8'h00 : (sl_mem.exists(key) ? sl_mem[key] : def_val(k, s_addr[11:0]));
                        cd[k] = slave_lat(k);
                    end
                end
            end
            if (cyc == stray_cyc) rdy[0] = 1'b1;
            s1_ready = rdy[0]; s2_ready = rdy[1]; s3_ready = rdy[2];
            s1_rdata = rdy[0] ? rd[0] : 8'hEE;
            s2_rdata = rdy[1] ? rd[1] : 8'hEE;
            s3_rdata = rdy[2] ? rd[2] : 8'hEE;
        end
    end

    // Monitor: checks bus strobes and done pulses against the scoreboard queue.
    initial begin
        exp_t e;
        bit   md;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (s_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected s_valid", 1, 0);
                    end else begin
                        e = exp_q[0];
                        chk("s_valid cycle", cyc, e.vcyc);
                        chk("s_sel", s_sel, e.sel);
                        chk("s_addr", s_addr, e.addr);
                        chk("s_mode", s_mode, e.mode);
                        chk("s_wdata", s_wdata, e.wdata);
                        chk("owner grant", e.m ? m1_grant : m0_grant, 1);
                        chk("other grant", e.m ? m0_grant : m1_grant, 0);
                    end
                end
                if (m0_done && m1_done) begin
                    chk("dual done", 1, 0);
                end else if (m0_done || m1_done) begin
                    md = m1_done;
                    if (exp_q.size() == 0) begin
                        chk("unexpected done", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("done master", md, e.m);
                        chk("done cycle", cyc, e.dcyc);
                        chk("done err", md ? m1_err : m0_err, e.err);
                        chk("done rdata", md ? m1_rdata : m0_rdata, e.rdata);
                        chk("other rdata held", md ? m0_rdata : m1_rdata, last_rd[md ? 0 : 1]);
                        chk("grant in done", {m0_grant, m1_grant}, 0);
                        chk("s_sel in done", s_sel, 0);
                        last_rd[e.m ? 1 : 0] = e.rdata;
                    end
                end
                if (!m0_done) begin
                    chk("m0_err quiet", m0_err, 0);
                    chk("m0_rdata held", m0_rdata, last_rd[0]);
                end
                if (!m1_done) begin
                    chk("m1_err quiet", m1_err, 0);
                    chk("m1_rdata held", m1_rdata, last_rd[1]);
                end
                if (rst) last_rd = '{8'h00, 8'h00};
            end
        end
    end

    task automatic check_reset(input string tag);
        chk({tag, " grants"}, {m0_grant, m1_grant}, 0);
        chk({tag, " dones"}, {m0_done, m1_done}, 0);
        chk({tag, " errs"}, {m0_err, m1_err}, 0);
        chk({tag, " m0_rdata"}, m0_rdata, 0);
        chk({tag, " m1_rdata"}, m1_rdata, 0);
        chk({tag, " s_valid"}, s_valid, 0);
        chk({tag, " s_sel"}, s_sel, 0);
        chk({tag, " s_mode"}, s_mode, 0);
        chk({tag, " s_addr"}, s_addr, 0);
        chk({tag, " s_wdata"}, s_wdata, 0);
    endtask

    task automatic run_round(input bit u0, input bit u1,
                             input logic md0, input logic [15:0] a0, input logic [7:0] w0,
                             input logic md1, input logic [15:0] a1, input logic [7:0] w1);
        int t, d, budget;
        bit first;
        t = cyc;
        m0_mode = md0; m0_addr = a0; m0_wdata = w0;
        m1_mode = md1; m1_addr = a1; m1_wdata = w1;
        m0_req = u0; m1_req = u1;
        first = (u0 && u1) ? ptr_m : u1;
        if (first) model_txn(1'b1, md1, a1, w1, t, d);
        else       model_txn(1'b0, md0, a0, w0, t, d);
        if (u0 && u1) begin
            if (first) model_txn(1'b0, md0, a0, w0, d + 1, d);
            else       model_txn(1'b1, md1, a1, w1, d + 1, d);
        end
        budget = 300;
        while ((exp_q.size() != 0 || m0_req || m1_req) && budget > 0) begin
            @(posedge clk); #1;
            if (m0_done) m0_req = 1'b0;
            if (m1_done) m1_req = 1'b0;
            budget--;
        end
        if (budget == 0) begin
            chk("round completes", 0, 1);
            exp_q.delete();
            m0_req = 1'b0; m1_req = 1'b0;
        end
    endtask

    function automatic logic [15:0] rnd_addr();
        int pg;
        logic [3:0] p;
        pg = $urandom_range(0, 4);
        if (pg < 3) p = 4'(pg);
        else if (pg == 3) p = 4'h3;
        else p = 4'($urandom_range(4, 15));
        return {p, 9'h000, 3'($urandom_range(0, 7))};
    endfunction

    initial begin
        int t, d;
        bit u0, u1;
        rst = 1'b1;
        m0_req = 1'b1; m0_mode = 1'b0; m0_addr = 16'h0004; m0_wdata = 8'h00;
        m1_req = 1'b1; m1_mode = 1'b0; m1_addr = 16'h1008; m1_wdata = 8'h00;
        @(posedge clk); #1;
        mon_en = 1'b1;
        repeat (3) begin
            check_reset("reset");
            @(posedge clk); #1;
        end
        rst = 1'b0; m0_req = 1'b0; m1_req = 1'b0;
        @(posedge clk); #1;

        run_round(1, 0, 1'b1, 16'h2010, 8'hA5, 1'b0, 16'h0000, 8'h00);
        run_round(1, 0, 1'b0, 16'h2010, 8'h00, 1'b0, 16'h0000, 8'h00);
        chk("m0 readback", m0_rdata, 8'hA5);
        run_round(1, 1, 1'b0, 16'h0004, 8'h11, 1'b0, 16'h1008, 8'h22);
        run_round(1, 1, 1'b0, 16'h0004, 8'h11, 1'b0, 16'h1008, 8'h22);
        run_round(0, 1, 1'b0, 16'h0000, 8'h00, 1'b0, 16'h5000, 8'h33);
        chk("m1 miss rdata", m1_rdata, 8'h00);

        s2_dead = 1'b1;
        stray_cyc = cyc + 5;
        run_round(1, 0, 1'b0, 16'h1004, 8'h44, 1'b0, 16'h0000, 8'h00);
        s2_dead = 1'b0;
        stray_cyc = -1;

        // Abort a slave-3 read with reset in its third cycle.
        t = cyc;
        m0_mode = 1'b0; m0_addr = 16'h2010; m0_wdata = 8'h00; m0_req = 1'b1;
        model_txn(1'b0, 1'b0, 16'h2010, 8'h00, t, d);
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst = 1'b1; m0_req = 1'b0;
        exp_q.delete(0);
        @(posedge clk); #1;
        rst = 1'b0;
        ptr_m = 1'b0;
        check_reset("abort");
        repeat (4) begin
            @(posedge clk); #1;
        end
        run_round(1, 0, 1'b0, 16'h2010, 8'h00, 1'b0, 16'h0000, 8'h00);
        chk("post-abort readback", m0_rdata, 8'hA5);

        for (int r = 0; r < 40; r++) begin
            u0 = 1'($urandom_range(0, 1));
            u1 = 1'($urandom_range(0, 1));
            if (!u0 && !u1) u0 = 1'b1;
            s2_dead = ($urandom_range(0, 7) == 0);
            run_round(u0, u1,
                      1'($urandom_range(0, 1)), rnd_addr(), 8'($urandom_range(0, 255)),
                      1'($urandom_range(0, 1)), rnd_addr(), 8'($urandom_range(0, 255)));
            s2_dead = 1'b0;
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/bus_arbiter_2m3s.md
# bus_arbiter_2m3s

Two-master, three-slave system-bus controller. It arbitrates single-beat read/write transactions from two masters round-robin and decodes the address to a one-hot slave select. It drives the shared slave request bus (mode/addr/wdata/valid) and waits for the selected slave's `ready` pulse. It returns read data, or an error on a decode miss or timeout, to the winning master.

## Interface
Parameters:
- `TIMEOUT`, 15: maximum WAIT cycles without slave `ready` before the transaction is aborted with an error; range 1..255.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `m0_req`, `m1_req` in 1: transaction request. Sampled only in IDLE.
- `m0_mode`, `m1_mode` in 1: 1 = write, 0 = read.
- `m0_addr`, `m1_addr` in 16: byte address.
- `m0_wdata`, `m1_wdata` in 8: write data.
- `m0_grant`, `m1_grant` out 1: high from ADDR through WAIT for the owning master.
- `m0_done`, `m1_done` out 1: one-cycle completion pulse.
- `m0_err`, `m1_err` out 1: valid with `done`. 1 = decode miss or timeout.
- `m0_rdata`, `m1_rdata` out 8: read data, valid with `done`. Held until the next `done` to that master.
- `s_mode` out 1, `s_addr` out 16, `s_wdata` out 8: shared slave request bus, driven from latched registers.
- `s_valid` out 1: request strobe to slaves.
- `s_sel` out 3: one-hot slave select; bit k drives slave k+1's `sl` input.
- `s1_rdata`, `s2_rdata`, `s3_rdata` in 8: slave read data.
- `s1_ready`, `s2_ready`, `s3_ready` in 1: slave completion pulses.

## Operation
- Address map on `addr[15:12]`:
  - 0x0 selects slave 1, 0x1 selects slave 2, 0x2 selects slave 3. Each window is 4 KB.
  - 0x3–0xF are unmapped.
  - The full 16-bit address is forwarded; slaves use `[11:0]`.
- Arbitration is round-robin with a 1-bit priority pointer.
  - Reset sets the pointer to favour m0.
  - If only one master requests, it wins.
  - If both request, the pointer's master wins.
  - After each completed transaction (including errors), the pointer moves to the other master.
- State machine:
  - **IDLE**: with any `req`, select the winner and latch its mode/addr/wdata, owner id and decoded select. A mapped address goes to ADDR; an unmapped one goes to DONE with error set. With no `req`, stay.
  - **ADDR** (1 cycle): `s_valid`=1 and `s_sel` = decoded one-hot; the owner's `grant`=1. Clear the wait counter. Go to WAIT.
  - **WAIT**: `s_valid`=0, `s_sel` held, `grant` held, counter increments each cycle.
    - If the selected slave's `ready`=1, capture that slave's `rdata` (reads only; writes leave the capture at 0x00), err=0, go to DONE.
    - Otherwise, if the counter reaches `TIMEOUT`, set err=1 and rdata=0x00, go to DONE.
    - `ready` from non-selected slaves is ignored.
  - **DONE** (1 cycle): the owner's `done`=1, with `err` and `rdata` driven. `grant`=0 and `s_sel`=0. Update the pointer. Go to IDLE.
- `s_mode`/`s_addr`/`s_wdata` hold their last latched value outside ADDR.
- The non-owner's `done`/`err`/`rdata` do not change.
- A master must hold its request fields stable while `req` is high and not yet granted.
- A `req` still high in the IDLE cycle after `done` is treated as a new request.

## Timing
- Reset values:
  - All grant/done/err outputs 0.
  - Both `mX_rdata` 0x00.
  - `s_valid`=0, `s_sel`=3'b000, `s_mode`=0, `s_addr`=0x0000, `s_wdata`=0x00.
  - State IDLE, pointer favouring m0, counter 0.
- `rst` asserted in any state aborts the transaction immediately. No `done` is issued for the aborted transfer.
- Latency, with `req` sampled in IDLE at cycle T:
  - ADDR at T+1.
  - WAIT from T+2.
  - For a slave whose `ready` appears at cycle R, `done` is at R+1.
  - Slave 3 (4-cycle response): `ready` at T+5, `done` at T+6.
- Decode miss: `done` with `err`=1 at T+1; `s_valid` never asserted.
- Timeout: `done` with `err`=1 at T+2+`TIMEOUT`.
- A `ready` and a timeout in the same cycle: `ready` wins, err=0.
- Back-to-back requests: minimum 4 cycles between `done` pulses when the slave's `ready` arrives in the first WAIT cycle; requests arriving during ADDR/WAIT/DONE wait for IDLE.

## Test plan
- Reset with both `req` high: all outputs at reset values; `s_valid`=0 throughout reset.
- m0 writes 0xA5 to 0x2010, then reads 0x2010, with slave 3 model:
  - `s_sel`=3'b100 and `s_valid` pulse at T+1.
  - Write: `m0_done` at T+6 with err=0.
  - Read: `m0_rdata`=0xA5.
- Both masters request simultaneously from reset, m0 reading 0x0004 and m1 reading 0x1008:
  - m0 is granted first, m1 second.
  - A repeated simultaneous request then grants m0 first again, because the pointer returns to m0 after m1 completes.
- m1 accesses 0x5000: `m1_done` and `m1_err`=1 at T+1, `m1_rdata`=0x00, `s_valid` never high.
- Slave 2 with `ready` tied low and `TIMEOUT`=15: `done` with err=1 at T+17. A stray `s1_ready` pulse during WAIT is ignored.
- `rst` pulsed at T+3 of a slave-3 read: no `done`; IDLE with reset outputs at T+4; the next request completes normally.
